// File: rtl/core_mem_fill_check_master.sv
`default_nettype none
// core_mem_fill_check_master: Avalon-MM master that fills a RAM block with
// pattern + i*step, or reads a block back into a 32-bit additive checksum.
module core_mem_fill_check_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  input  logic [DATA_W-1:0]   pattern,
  input  logic [DATA_W-1:0]   step,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;
  logic [DATA_W-1:0]   data;
  logic [DATA_W-1:0]   step_q;

  logic                last_word;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   data_next;
  logic [DATA_W-1:0]   sum_next;

  assign last_word = (remaining == LEN_W'(1));
  assign addr_next = addr + ADDR_W'(1);
  assign data_next = data + step_q;
  assign sum_next  = checksum + avm_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      addr           <= '0;
      remaining      <= '0;
      data           <= '0;
      step_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= length;
            data      <= pattern;
            step_q    <= step;
            checksum  <= '0;
            if (length == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              busy           <= 1'b1;
              avm_byteenable <= '1;
              avm_chipselect <= 1'b1;
              avm_address    <= base_addr;
              if (mode) begin
                state    <= S_RD_REQ;
                avm_read <= 1'b1;
              end else begin
                state         <= S_WR;
                avm_write     <= 1'b1;
                avm_writedata <= pattern;
              end
            end
          end
        end

        S_WR: begin
          if (!avm_waitrequest) begin
            addr      <= addr_next;
            data      <= data_next;
            remaining <= remaining - LEN_W'(1);
            if (last_word) begin
              state          <= S_FIN;
              done           <= 1'b1;
              busy           <= 1'b0;
              avm_write      <= 1'b0;
              avm_chipselect <= 1'b0;
              avm_byteenable <= '0;
            end else begin
              avm_address   <= addr_next;
              avm_writedata <= data_next;
            end
          end
        end

        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            // Zero-latency slave: data returns in the accept cycle itself.
            if (avm_readdatavalid) begin
              checksum  <= sum_next;
              addr      <= addr_next;
              remaining <= remaining - LEN_W'(1);
              if (last_word) begin
                state          <= S_FIN;
                done           <= 1'b1;
                busy           <= 1'b0;
                avm_read       <= 1'b0;
                avm_chipselect <= 1'b0;
                avm_byteenable <= '0;
              end else begin
                avm_address <= addr_next;
              end
            end else begin
              state          <= S_RD_WAIT;
              avm_read       <= 1'b0;
              avm_chipselect <= 1'b0;
            end
          end
        end

        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            checksum  <= sum_next;
            addr      <= addr_next;
            remaining <= remaining - LEN_W'(1);
            if (last_word) begin
              state          <= S_FIN;
              done           <= 1'b1;
              busy           <= 1'b0;
              avm_byteenable <= '0;
            end else begin
              state          <= S_RD_REQ;
              avm_read       <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_address    <= addr_next;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
